// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: operands shift out LSB first through a 1-bit full adder,
// result shifts into SUM from the MSB end; IDLE -> ADD (WIDTH cycles) -> FIN.

module serial_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic hs, hc, hc2;

    // two half adders with their carries merged
    assign hs  = a ^ b;
    assign hc  = a & b;
    assign s   = hs ^ ci;
    assign hc2 = hs & ci;
    assign co  = hc | hc2;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

    state_t           state, nstate;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s, bit_co;
    logic             last;

    serial_adder_bit u_bit (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (START) nstate = ADD;
            ADD:     if (last)  nstate = FIN;
            FIN:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            ADD:     BUSY = 1'b1;
            FIN:     begin BUSY = 1'b1; DONE = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            SUM   <= '0;
            COUT  <= 1'b0;
        end else if (state == IDLE && START) begin
            opa   <= A;
            opb   <= B;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == ADD) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            carry <= bit_co;
            cnt   <= cnt + CW'(1);
            SUM   <= {bit_s, SUM[WIDTH-1:1]};
            if (last) COUT <= bit_co;
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, corner
// sequences, and random operations against an arithmetic reference.

module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk, rst_n, start;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .START    (start),
        .A        (a),
        .B        (b),
        .BUSY     (busy),
        .DONE     (done),
        .SUM      (sum),
        .COUT     (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic [WIDTH-1:0] esum;
        logic             ecout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one operation from IDLE; optionally re-pulses START and changes A/B mid-ADD.
    task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                         input bit scramble, output int lat, output int busy_cyc,
                         output int done_cnt, output logic [WIDTH:0] res);
        @(negedge clk);
        a = oa; b = ob; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1; busy_cyc = 0; done_cnt = 0;
        for (int e = 0; e < WIDTH + 6; e++) begin
            if (busy) busy_cyc++;
            if (done) begin done_cnt++; lat = e; end
            if (scramble && e == 2) begin a = 8'hAA; b = 8'hAA; start = 1'b1; end
            if (scramble && e == 4) start = 1'b0;
            @(negedge clk);
        end
        res = {cout, sum};
    endtask

    initial begin
        vec_t vecs[5];
        int lat, bc, dc;
        logic [WIDTH:0] res, expv;
        int dpos[$];
        logic [WIDTH-1:0] ra, rb;

        vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h5A, 8'h3C, 8'h96, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].va, vecs[i].vb, 1'b0, lat, bc, dc, res);
            chk($sformatf("vec%0d_sum", i),  32'(res[WIDTH-1:0]), 32'(vecs[i].esum));
            chk($sformatf("vec%0d_cout", i), 32'(res[WIDTH]),     32'(vecs[i].ecout));
            chk($sformatf("vec%0d_lat", i),  32'(lat), 32'(WIDTH));
            chk($sformatf("vec%0d_busy", i), 32'(bc),  32'(WIDTH + 1));
            chk($sformatf("vec%0d_done", i), 32'(dc),  32'd1);
        end

        // START re-pulse and operand change during ADD
        do_op(8'h21, 8'h43, 1'b1, lat, bc, dc, res);
        chk("scramble_res",  32'(res), 32'h064);
        chk("scramble_done", 32'(dc),  32'd1);
        chk("scramble_busy", 32'(busy), 32'd0);

        // reset during the 4th ADD cycle
        @(negedge clk);
        a = 8'h55; b = 8'h33; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum",  32'(sum),  32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int e = 0; e < WIDTH + 4; e++) begin
            if (done) dc++;
            @(negedge clk);
        end
        chk("midrst_nodone", 32'(dc), 32'd0);
        do_op(8'h12, 8'h34, 1'b0, lat, bc, dc, res);
        chk("postrst_res", 32'(res), 32'h046);

        // START held high across reset release is taken on the first edge
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; a = 8'h03; b = 8'h04;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_busy", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (WIDTH) @(negedge clk);
        chk("rel_done", 32'(done), 32'd1);
        chk("rel_res",  32'({cout, sum}), 32'h007);
        @(negedge clk);
        chk("rel_idle", 32'({busy, done}), 32'd0);

        // START held high: back-to-back operations
        @(negedge clk);
        a = 8'h80; b = 8'h80; start = 1'b1;
        for (int n = 0; n < 5 * (WIDTH + 2); n++) begin
            @(negedge clk);
            if (done) begin
                dpos.push_back(n);
                chk("b2b_res", 32'({cout, sum}), 32'h100);
            end
        end
        start = 1'b0;
        chk("b2b_count_ok", 32'(dpos.size() >= 4), 32'd1);
        for (int i = 1; i < dpos.size(); i++)
            chk("b2b_period", 32'(dpos[i] - dpos[i-1]), 32'(WIDTH + 2));
        repeat (WIDTH + 4) @(negedge clk);

        // random operations against the arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            expv = {1'b0, ra} + {1'b0, rb};
            do_op(ra, rb, bit'($urandom_range(0, 1)), lat, bc, dc, res);
            chk($sformatf("rand%0d_res", i), 32'(res), 32'(expv));
            if (lat != WIDTH || dc != 1)
                chk($sformatf("rand%0d_timing", i), 32'({lat[15:0], dc[15:0]}),
                    32'({16'(WIDTH), 16'd1}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete, limit 5000000");
        $fatal(1, "timeout");
    end
endmodule
